// File: rtl/sample_line_packer_if.sv
// rtl/sample_line_packer_if.sv - line write port from the packer to the DRAM write controller
interface sample_line_packer_if #(
  parameter int MEM_DATA_WIDTH = 128,
  parameter int LANES          = 4
);
  logic                      mem_wr_valid;
  logic                      mem_wr_ready;
  logic [MEM_DATA_WIDTH-1:0] mem_wr_data;
  logic [27:0]               mem_wr_addr;
  logic [LANES-1:0]          mem_wr_mask;

  modport master (
    output mem_wr_valid, mem_wr_data, mem_wr_addr, mem_wr_mask,
    input  mem_wr_ready
  );

  modport slave (
    input  mem_wr_valid, mem_wr_data, mem_wr_addr, mem_wr_mask,
    output mem_wr_ready
  );
endinterface

// File: rtl/sample_line_packer.sv
// rtl/sample_line_packer.sv - packs sample packets into masked memory lines behind a line FIFO
// Optional: SAMPLE_LINE_PACKER_DROP_CNT_EN adds a saturating drop_count output.
module sample_line_packer #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int MEM_DATA_WIDTH      = 128,
  parameter int FIFO_DEPTH          = 8,
  parameter int AFULL_MARGIN        = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket,
  input  logic                           write_enable,
  input  logic [31:0]                    sample_number,
  input  logic                           flush,
  output logic                           pageFull,
  output logic                           idle,
  output logic                           overflow,
`ifdef SAMPLE_LINE_PACKER_DROP_CNT_EN
  output logic [15:0]                    drop_count,
`endif
  sample_line_packer_if.master           mem_wr
);
  localparam int SPW   = SAMPLE_PACKET_WIDTH;
  localparam int MDW   = MEM_DATA_WIDTH;
  localparam int LANES = MDW / SPW;
  localparam int LB    = $clog2(LANES);
  localparam int LW    = 32 - LB;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic [MDW-1:0]   data;
    logic [27:0]      addr;
    logic [LANES-1:0] mask;
  } line_t;

  logic [MDW-1:0]   stg_data_q, stg_data_d;
  logic [LW-1:0]    stg_line_q, stg_line_d;
  logic [LANES-1:0] stg_mask_q, stg_mask_d;
  logic             stg_seal_q, stg_seal_d;
  line_t            pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  line_t            mem_q [FIFO_DEPTH];
  line_t            mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [LB-1:0]    lane;
  logic [LW-1:0]    line;
  logic             stg_open, brk, done;
  logic [MDW-1:0]   mrg_data;
  logic [LANES-1:0] mrg_mask;
  line_t            old_line, mrg_line, c1, c2, push_line, head;
  logic             c1_v, c2_v, push_v;
  logic             pop, full, drop, wr;

  // Completed lines this cycle form an ordered list: pend, then c1, then c2.
  // Only the oldest is pushed; a second leftover waits in staging marked sealed.
  always_comb begin
    lane     = sample_number[LB-1:0];
    line     = sample_number[31:LB];
    stg_open = (|stg_mask_q) & ~stg_seal_q;
    brk      = stg_seal_q | (write_enable & stg_open & (line != stg_line_q));
    done     = write_enable & (flush | (lane == LB'(LANES - 1)));

    old_line.data = stg_data_q;
    old_line.addr = stg_line_q[27:0];
    old_line.mask = stg_mask_q;

    mrg_data = (stg_open & ~brk) ? stg_data_q : '0;
    mrg_mask = (stg_open & ~brk) ? stg_mask_q : '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane == LB'(k)) begin
        mrg_data[k*SPW +: SPW] = samplePacket;
        mrg_mask[k]            = 1'b1;
      end
    end
    mrg_line.data = mrg_data;
    mrg_line.addr = line[27:0];
    mrg_line.mask = mrg_mask;

    c1_v       = 1'b0;
    c1         = '0;
    c2_v       = 1'b0;
    c2         = '0;
    stg_data_d = stg_data_q;
    stg_line_d = stg_line_q;
    stg_mask_d = stg_mask_q;
    stg_seal_d = 1'b0;

    if (brk | (~write_enable & flush & stg_open)) begin
      c1_v       = 1'b1;
      c1         = old_line;
      stg_data_d = '0;
      stg_mask_d = '0;
    end
    if (write_enable) begin
      if (done) begin
        if (c1_v) begin
          c2_v = 1'b1;
          c2   = mrg_line;
        end else begin
          c1_v = 1'b1;
          c1   = mrg_line;
        end
        stg_data_d = '0;
        stg_mask_d = '0;
      end else begin
        stg_data_d = mrg_data;
        stg_mask_d = mrg_mask;
        stg_line_d = line;
      end
    end

    push_v    = 1'b0;
    push_line = '0;
    pend_v_d  = 1'b0;
    pend_d    = '0;
    if (pend_v_q) begin
      push_v    = 1'b1;
      push_line = pend_q;
      pend_v_d  = c1_v;
      pend_d    = c1;
      if (c2_v) begin
        stg_data_d = c2.data;
        stg_mask_d = c2.mask;
        stg_line_d = line;
        stg_seal_d = 1'b1;
      end
    end else begin
      push_v    = c1_v;
      push_line = c1;
      pend_v_d  = c2_v;
      pend_d    = c2;
    end
  end

  always_comb begin
    pop        = mem_wr.mem_wr_valid & mem_wr.mem_wr_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    drop       = push_v & full & ~pop;
    wr         = push_v & ~drop;
    mem_d      = mem_q;
    if (wr) mem_d[wr_ptr_q] = push_line;
    wr_ptr_d   = wr_ptr_q + PW'(wr);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(wr) - CW'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_data_q <= '0;
      stg_line_q <= '0;
      stg_mask_q <= '0;
      stg_seal_q <= 1'b0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_line_q <= stg_line_d;
      stg_mask_q <= stg_mask_d;
      stg_seal_q <= stg_seal_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SAMPLE_LINE_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  // Head is gated so the port reads all-zero whenever nothing is offered.
  always_comb begin
    head                = mem_q[rd_ptr_q];
    mem_wr.mem_wr_valid = (count_q != '0);
    mem_wr.mem_wr_data  = mem_wr.mem_wr_valid ? head.data : '0;
    mem_wr.mem_wr_addr  = mem_wr.mem_wr_valid ? head.addr : '0;
    mem_wr.mem_wr_mask  = mem_wr.mem_wr_valid ? head.mask : '0;
  end

  assign pageFull = (count_q >= CW'(FIFO_DEPTH - AFULL_MARGIN)) | pend_v_q;
  assign idle     = (count_q == '0) & ~(|stg_mask_q) & ~pend_v_q;
  assign overflow = overflow_q;
endmodule
